// File: rtl/serial_alu_seq_if.sv
// Handshake and operand/result bundle between a control FSM (master) and the
// digit-serial ALU sequencer (slave).
interface serial_alu_seq_if #(
    parameter int WORD_W = 32
);
    logic              start;
    logic [2:0]        op;
    logic              b_imm;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              busy;
    logic              done;
    logic [WORD_W-1:0] result;
    logic              carry;
    logic              overflow;
    logic              zero;

    modport master (
        output start, op, b_imm, a, b,
        input  busy, done, result, carry, overflow, zero
    );

    modport slave (
        input  start, op, b_imm, a, b,
        output busy, done, result, carry, overflow, zero
    );
endinterface

// File: rtl/serial_alu_seq.sv
// Digit-serial integer ALU: one WORD_W operation processed DIGIT_W bits per
// cycle, LSB digit first, behind a start/busy/done handshake.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for start; result/flags hold the last operation
//   S_RUN  | one digit per edge; final digit sets flags, pulses done
module serial_alu_seq #(
    parameter int WORD_W  = 32,
    parameter int DIGIT_W = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_alu_seq_if.slave bus
);
    localparam int NDIGITS = WORD_W / DIGIT_W;
    localparam int CNT_W   = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

    typedef enum logic {S_IDLE, S_RUN} state_e;
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_SLTU, OP_PASSB
    } op_e;

    state_e             state_q, state_d;
    op_e                op_q, op_d;
    logic [WORD_W-1:0]  a_q, a_d;
    logic [WORD_W-1:0]  b_q, b_d;
    logic               c_q, c_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WORD_W-1:0]  res_q, res_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic               done_q, done_d;

    logic [DIGIT_W-1:0] a_dig, b_dig, r_dig;
    logic [DIGIT_W:0]   sum;
    logic [WORD_W-1:0]  b_ext;
    logic               is_arith, is_sub, last, ovf_dig;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= OP_ADD;
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        done_d  = 1'b0;

        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_dig = a_q[i*DIGIT_W +: DIGIT_W];
                b_dig = b_q[i*DIGIT_W +: DIGIT_W];
            end
        end

        // b_q already holds ~b for subtract-type ops, so one adder serves all
        sum      = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT_W{1'b0}}, c_q};
        is_arith = (op_q == OP_ADD) || (op_q == OP_SUB) ||
                   (op_q == OP_SLT) || (op_q == OP_SLTU);
        last     = (cnt_q == CNT_W'(NDIGITS - 1));
        ovf_dig  = (a_dig[DIGIT_W-1] == b_dig[DIGIT_W-1]) &&
                   (sum[DIGIT_W-1] != a_dig[DIGIT_W-1]);

        case (op_q)
            OP_AND:   r_dig = a_dig & b_dig;
            OP_OR:    r_dig = a_dig | b_dig;
            OP_XOR:   r_dig = a_dig ^ b_dig;
            OP_PASSB: r_dig = b_dig;
            default:  r_dig = sum[DIGIT_W-1:0];
        endcase

        b_ext  = {{(WORD_W-12){bus.b[11]}}, bus.b[11:0]};
        is_sub = (bus.op == 3'd1) || (bus.op == 3'd5) || (bus.op == 3'd6);

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    op_d    = op_e'(bus.op);
                    a_d     = bus.a;
                    b_d     = bus.b_imm ? b_ext : bus.b;
                    if (is_sub) b_d = ~b_d;
                    c_d     = is_sub;
                    cnt_d   = '0;
                    res_d   = '0;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    zero_d  = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int i = 0; i < NDIGITS; i++) begin
                    if (cnt_q == CNT_W'(i)) res_d[i*DIGIT_W +: DIGIT_W] = r_dig;
                end
                if (is_arith) c_d = sum[DIGIT_W];
                cnt_d = cnt_q + CNT_W'(1);
                if (last) begin
                    carry_d = is_arith && sum[DIGIT_W];
                    ovf_d   = ((op_q == OP_ADD) || (op_q == OP_SUB) ||
                               (op_q == OP_SLT)) && ovf_dig;
                    if (op_q == OP_SLT) begin
                        res_d    = '0;
                        res_d[0] = sum[DIGIT_W-1] ^ ovf_dig;
                    end else if (op_q == OP_SLTU) begin
                        res_d    = '0;
                        res_d[0] = ~sum[DIGIT_W];
                    end
                    zero_d  = (res_d == '0);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = done_q;
    assign bus.result   = res_q;
    assign bus.carry    = carry_q;
    assign bus.overflow = ovf_q;
    assign bus.zero     = zero_q;
endmodule

// File: doc/serial_alu_seq.md
# serial_alu_seq

Digit-serial integer ALU sequencer, the parametrised successor of the nibble-loop ALU used by the multicycle RV32I control FSM. It processes a WORD_W-bit operation DIGIT_W bits per cycle, LSB digit first, behind a start/busy/done handshake. It supports add, sub, logic, signed/unsigned set-less-than and immediate sign-extension of operand b. The control FSM issues one operation per start and stalls on busy, as it does today for PC increment, OP_IMM and load/store address calculation.

## Interface
- WORD_W, 32, operand/result width; must be a multiple of DIGIT_W, ≥ 12
- DIGIT_W, 4, bits processed per cycle; NDIGITS = WORD_W/DIGIT_W; DIGIT_W = WORD_W gives a single-cycle operation
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only while busy = 0
- op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 PASS_B
- b_imm  in  1  1: b is replaced by sign-extended b[11:0] at acceptance
- a  in  WORD_W  operand a
- b  in  WORD_W  operand b
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse; result/flags valid
- result  out  WORD_W  result, held until the next accepted start
- carry  out  1  ADD: carry out of MSB; SUB/SLT/SLTU: 1 = no borrow (a ≥ b unsigned); else 0
- overflow  out  1  ADD/SUB/SLT: signed overflow of the add/sub; else 0
- zero  out  1  result == 0

## Operation
- States: IDLE, RUN. Reset: IDLE, busy = 0, done = 0, result = 0, carry = overflow = zero = 0, digit counter = 0.
- IDLE with start = 1 at an edge: latch op, a, and b (extended if b_imm). For SUB, SLT and SLTU, latch ~b. Clear result. Carry-in = 1 for SUB/SLT/SLTU, else 0. Counter = 0. Go to RUN, busy = 1.
- RUN, each edge: compute digit i = counter from the latched a and b digits and the internal carry. Write it into result[i*DIGIT_W +: DIGIT_W] and update the internal carry. Keep the sign bits needed for overflow. Increment the counter.
- Per-digit function: ADD/SUB/SLT/SLTU use a + b' + c. AND/OR/XOR are bitwise. PASS_B passes the b digit.
- Final digit (counter = NDIGITS-1):
  - Set the flags.
  - SLT: result = {0…, sign(a−b) XOR overflow}.
  - SLTU: result = {0…, ~carry}.
  - zero is computed on the final result.
  - Go to IDLE with busy = 0 and done = 1.
- start while busy = 1 is ignored. Operands are not re-sampled and no error is raised.
- a and b may change freely after acceptance.
- PASS_B with b_imm = 1 yields sext(b[11:0]).
- rst_n low at any time, including mid-RUN, immediately forces all reset values. The aborted operation produces no done.

## Timing
- Start accepted at edge E0: busy = 1 during the NDIGITS cycles after E0. Digit i is written at edge E(i+1).
- At edge E(NDIGITS): busy → 0, done → 1, result and flags final. done → 0 at E(NDIGITS+1).
- Latency from accepting edge to done: NDIGITS cycles (8 for defaults; 1 for DIGIT_W = WORD_W).
- Back-to-back operation: start = 1 in the done cycle is accepted at E(NDIGITS+1). Throughput is one op per NDIGITS+1 cycles.
- Intermediate result digits are visible during RUN. Only the done cycle and later are guaranteed.

## Test plan
- ADD, a = 0x000000FF, b = 4, defaults:
  - busy for exactly 8 cycles, then done for 1 cycle.
  - result = 0x00000103, carry = 0, overflow = 0, zero = 0.
- ADD with b_imm = 1, a = 123, b = 0x800:
  - result = 0xFFFFF87B (−1925), carry = 0.
- SUB, a = 5, b = 5:
  - result = 0, zero = 1, carry = 1.
- ADD, a = 0x7FFFFFFF, b = 1:
  - result = 0x80000000, overflow = 1, carry = 0.
- a = 0xFFFFFFFF, b = 1:
  - SLT: result = 1.
  - SLTU: result = 0, carry = 1.
- Handshake and reset:
  - Second start while busy (different operands) is ignored. The first result is unchanged and done occurs once.
  - rst_n pulsed at RUN digit 3 gives all outputs 0 and no done.
  - Parameter set WORD_W = 16, DIGIT_W = 8: 0x00FF + 0x0001 = 0x0100 with busy 2 cycles.
  - Parameter set DIGIT_W = WORD_W = 32: done on the cycle after acceptance.
